// File: rtl/paddle_input_pkg.sv
// Shared constants and types for the Pong paddle input front end.
// Holds the UART command bytes, the repeat FSM states and a counter-width helper.
package paddle_input_pkg;

  localparam logic [7:0] CMD_UP1 = 8'h77;  // 'w'
  localparam logic [7:0] CMD_DN1 = 8'h73;  // 's'
  localparam logic [7:0] CMD_UP2 = 8'h69;  // 'i'
  localparam logic [7:0] CMD_DN2 = 8'h6B;  // 'k'
  localparam logic [7:0] CMD_RST = 8'h72;  // 'r'

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  // Keeps a degenerate limit of 1 from producing a zero-width counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_repeat.sv
// One switch: debounce counter, stable level, rising-edge detect and
// hold-to-repeat FSM producing single-cycle move requests.
module switch_repeat
  import paddle_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 6250000,
  parameter int unsigned REPEAT_PERIOD  = 1250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Pulse
);

  localparam int unsigned DbW    = cnt_width(DEBOUNCE_LIMIT);
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = cnt_width(TmrMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);

  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            stable_q, stable_d, stable_prev_q;
  logic [TmrW-1:0] tmr_q, tmr_d;
  rpt_state_e      state_q, state_d;
  logic            rise;
  logic            pulse;

  // Any sample matching the stable level restarts the run of differing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (i_Raw == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      stable_d = i_Raw;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  // Release is checked first so it wins over a timer expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse   = 1'b0;
    if (!stable_q) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            pulse   = 1'b1;
            tmr_d   = '0;
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (tmr_q == DelayLast) begin
            pulse   = 1'b1;
            tmr_d   = '0;
            state_d = REPEAT;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        REPEAT: begin
          if (tmr_q == PeriodLast) begin
            pulse = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      db_cnt_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      tmr_q         <= '0;
      state_q       <= IDLE;
    end else begin
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      tmr_q         <= tmr_d;
      state_q       <= state_d;
    end
  end

  assign o_Level = stable_q;
  assign o_Pulse = pulse;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Pong input front end: four debounced, auto-repeating switches merged with
// UART paddle commands into registered single-cycle move and restart pulses.
module paddle_input_ctrl
  import paddle_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 6250000,
  parameter int unsigned REPEAT_PERIOD  = 1250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switch,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [3:0] o_Level,
  output logic [3:0] o_Move,
  output logic       o_Game_Rst
);

  logic [3:0] fsm_pulse;
  logic [3:0] uart_move;
  logic       uart_rst;
  logic [3:0] move_q;
  logic       game_rst_q;

  for (genvar n = 0; n < 4; n++) begin : g_sw
    switch_repeat #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_switch_repeat (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Raw  (i_Switch[n]),
      .o_Level(o_Level[n]),
      .o_Pulse(fsm_pulse[n])
    );
  end

  always_comb begin
    uart_move = '0;
    uart_rst  = 1'b0;
    if (i_RX_DV) begin
      case (i_RX_Byte)
        CMD_UP1: uart_move[0] = 1'b1;
        CMD_DN1: uart_move[1] = 1'b1;
        CMD_UP2: uart_move[2] = 1'b1;
        CMD_DN2: uart_move[3] = 1'b1;
        CMD_RST: uart_rst     = 1'b1;
        default: ;
      endcase
    end
  end

  // OR before the register so coincident sources collapse into one pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      move_q     <= '0;
      game_rst_q <= 1'b0;
    end else begin
      move_q     <= fsm_pulse | uart_move;
      game_rst_q <= uart_rst;
    end
  end

  assign o_Move     = move_q;
  assign o_Game_Rst = game_rst_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl with short debounce/repeat timings
// and a window-based reference model of the switch and UART behaviour.
module tb_paddle_input_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       i_Clk;
  logic       i_Rst;
  logic [3:0] i_Switch;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [3:0] o_Level;
  logic [3:0] o_Move;
  logic       o_Game_Rst;

  paddle_input_ctrl #(
    .DEBOUNCE_LIMIT(DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Switch  (i_Switch),
    .i_RX_DV   (i_RX_DV),
    .i_RX_Byte (i_RX_Byte),
    .o_Level   (o_Level),
    .o_Move    (o_Move),
    .o_Game_Rst(o_Game_Rst)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: level flips once the last DB samples all disagree with it;
  // pulses fall at press, press+RD, press+RD+k*RP while the level stays high.
  logic [3:0]    m_lvl, m_lvl_prev;
  logic [DB-1:0] win [4];
  int            nsamp [4];
  int            press_edge [4];
  int            edge_no = 0;
  logic [3:0]    exp_level, exp_move;
  logic          exp_grst;

  task automatic model_edge();
    logic [3:0] pulse;
    logic [3:0] umove;
    logic       ugr;
    int         d;
    edge_no++;
    if (i_Rst) begin
      m_lvl = '0; m_lvl_prev = '0;
      for (int n = 0; n < 4; n++) begin
        win[n] = '0; nsamp[n] = 0;
      end
      exp_level = '0; exp_move = '0; exp_grst = 1'b0;
      return;
    end
    pulse = '0; umove = '0; ugr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (m_lvl[n] && !m_lvl_prev[n]) begin
        press_edge[n] = edge_no;
        pulse[n] = 1'b1;
      end else if (m_lvl[n]) begin
        d = edge_no - press_edge[n];
        if (d >= RD && ((d - RD) % RP) == 0) pulse[n] = 1'b1;
      end
      win[n] = {win[n][DB-2:0], i_Switch[n]};
      if (nsamp[n] < DB) nsamp[n]++;
    end
    m_lvl_prev = m_lvl;
    for (int n = 0; n < 4; n++)
      if (nsamp[n] == DB && win[n] == {DB{~m_lvl[n]}}) m_lvl[n] = ~m_lvl[n];
    if (i_RX_DV) begin
      case (i_RX_Byte)
        8'h77: umove[0] = 1'b1;
        8'h73: umove[1] = 1'b1;
        8'h69: umove[2] = 1'b1;
        8'h6B: umove[3] = 1'b1;
        8'h72: ugr = 1'b1;
        default: ;
      endcase
    end
    exp_level = m_lvl;
    exp_move  = pulse | umove;
    exp_grst  = ugr;
  endtask

  task automatic tick(input logic [3:0] sw, input logic rst, input logic dv,
                      input logic [7:0] b);
    i_Switch = sw; i_Rst = rst; i_RX_DV = dv; i_RX_Byte = b;
    @(posedge i_Clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(4'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(4'hF, 1'b1, 1'b1, 8'h77);
      n_chk++;
      if ({o_Level, o_Move, o_Game_Rst} !== 9'h0)
        $display("FAIL reset: got level=%b move=%b grst=%b, want all 0", o_Level, o_Move,
                 o_Game_Rst);
      else n_pass++;
    end
    settle(DB + 2);
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DB; k++) begin
        tick((k < DB - 1) ? 4'h1 : 4'h0, 1'b0, 1'b0, 8'h00);
        n_chk++;
        if ({o_Level, o_Move} !== 8'h00 || o_Level !== exp_level)
          $display("FAIL glitch: got level=%b move=%b, want 0000 0000", o_Level, o_Move);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold_release();
    int got[$];
    int exp_p [7];
    int rise_k = 0, fall_k = 0;
    exp_p = '{5, 25, 30, 35, 40, 45, 50};
    for (int k = 1; k <= 62; k++) begin
      tick((k <= 50) ? 4'h1 : 4'h0, 1'b0, 1'b0, 8'h00);
      n_chk++;
      if (o_Level !== exp_level || o_Move !== exp_move)
        $display("FAIL hold edge %0d: got level=%b move=%b, want level=%b move=%b", k,
                 o_Level, o_Move, exp_level, exp_move);
      else n_pass++;
      if (o_Move[0]) got.push_back(k);
      if (o_Level[0] && rise_k == 0) rise_k = k;
      if (!o_Level[0] && rise_k != 0 && fall_k == 0) fall_k = k;
    end
    n_chk++;
    if (rise_k !== 4) $display("FAIL hold_rise: got edge %0d, want 4", rise_k);
    else n_pass++;
    n_chk++;
    if (fall_k !== 54) $display("FAIL hold_fall: got edge %0d, want 54", fall_k);
    else n_pass++;
    n_chk++;
    if (got.size() !== 7) $display("FAIL hold_count: got %0d pulses, want 7", got.size());
    else n_pass++;
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_p[i])
        $display("FAIL hold_pulse%0d: got edge %0d, want %0d", i, got[i], exp_p[i]);
      else n_pass++;
    end
  endtask

  task automatic test_early_release();
    int got[$];
    for (int ph = 0; ph < 2; ph++) begin
      got.delete();
      for (int k = 1; k <= 15 + 10; k++) begin
        tick((k <= ((ph == 0) ? 15 : 10)) ? 4'h2 : 4'h0, 1'b0, 1'b0, 8'h00);
        if (o_Move[1]) got.push_back(k);
      end
      n_chk++;
      if (got.size() !== 1 || got[0] !== 5)
        $display("FAIL early_release ph%0d: got %0d pulses (first %0d), want 1 at edge 5", ph,
                 got.size(), (got.size() > 0) ? got[0] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_uart();
    logic       dv [10];
    logic [7:0] by [10];
    logic [3:0] em [10];
    logic       eg [10];
    dv = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    by = '{8'h73, 8'h53, 8'h72, 8'h77, 8'h77, 8'h69, 8'h6B, 8'h73, 8'h52, 8'h00};
    em = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h8, 4'h2, 4'h0, 4'h0};
    eg = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      tick(4'h0, 1'b0, dv[i], by[i]);
      n_chk++;
      if (o_Move !== em[i] || o_Game_Rst !== eg[i])
        $display("FAIL uart%0d byte=%h dv=%b: got move=%b grst=%b, want move=%b grst=%b", i,
                 by[i], dv[i], o_Move, o_Game_Rst, em[i], eg[i]);
      else n_pass++;
    end
  endtask

  task automatic test_coincident();
    int highs = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(4'h1, 1'b0, (k == 5), 8'h77);
      if (o_Move[0]) highs++;
      if (k == 5 || k == 6) begin
        n_chk++;
        if (o_Move[0] !== (k == 5))
          $display("FAIL coincident edge %0d: got move0=%b, want %b", k, o_Move[0], (k == 5));
        else n_pass++;
      end
    end
    n_chk++;
    if (highs !== 1) $display("FAIL coincident_width: got %0d high cycles, want 1", highs);
    else n_pass++;
    settle(DB + 2);
  endtask

  task automatic test_reset_mid_repeat();
    int rise_k = 0, press_k = 0;
    for (int k = 1; k <= 32; k++) tick(4'h4, 1'b0, 1'b0, 8'h00);
    tick(4'h4, 1'b1, 1'b0, 8'h00);
    n_chk++;
    if ({o_Level, o_Move, o_Game_Rst} !== 9'h0)
      $display("FAIL midrst_clear: got level=%b move=%b grst=%b, want all 0", o_Level, o_Move,
               o_Game_Rst);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick(4'h4, 1'b0, 1'b0, 8'h00);
      n_chk++;
      if (o_Level !== exp_level || o_Move !== exp_move)
        $display("FAIL midrst edge %0d: got level=%b move=%b, want level=%b move=%b", k,
                 o_Level, o_Move, exp_level, exp_move);
      else n_pass++;
      if (o_Level[2] && rise_k == 0) rise_k = k;
      if (o_Move[2] && press_k == 0) press_k = k;
    end
    n_chk++;
    if (rise_k !== 4 || press_k !== 5)
      $display("FAIL midrst_timing: got rise=%0d press=%0d, want rise=4 press=5", rise_k,
               press_k);
    else n_pass++;
    settle(DB + 2);
  endtask

  task automatic test_random();
    logic [3:0] sw = '0;
    logic [7:0] cmds [6];
    logic [7:0] b;
    logic       dv, rst;
    int         errs = 0;
    cmds = '{8'h77, 8'h73, 8'h69, 8'h6B, 8'h72, 8'h00};
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 11) == 0) sw[n] = ~sw[n];
      dv  = ($urandom_range(0, 3) == 0);
      b   = cmds[$urandom_range(0, 5)];
      if (b == 8'h00) b = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick(sw, rst, dv, b);
      n_chk++;
      if (o_Level !== exp_level || o_Move !== exp_move || o_Game_Rst !== exp_grst) begin
        if (errs < 10)
          $display("FAIL random step %0d: got %b/%b/%b, want %b/%b/%b", i, o_Level, o_Move,
                   o_Game_Rst, exp_level, exp_move, exp_grst);
        errs++;
      end else n_pass++;
    end
    settle(DB + 2);
  endtask

  initial begin
    i_Switch = '0; i_Rst = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = '0;
    test_reset();
    test_glitch();
    test_hold_release();
    test_early_release();
    test_uart();
    test_coincident();
    test_reset_mid_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Front-end control stage for the Pong game: debounces the four board switches, turns presses into one-cycle paddle-move pulses with hold-to-repeat, and merges paddle commands received as UART bytes. Sits between the raw switch pins / UART receiver and the Pong game core. Replaces the per-switch debounce-and-edge logic in the top level; its pulses drive the game's i_Sw1..i_Sw4 inputs directly.

## Interface
Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive differing samples needed to accept a new switch level (10 ms at 25 MHz)
- REPEAT_DELAY, 6250000, cycles from the press pulse to the first repeat pulse (250 ms)
- REPEAT_PERIOD, 1250000, cycles between subsequent repeat pulses (50 ms)

Ports:
- i_Clk  in  1  system clock; one clock domain
- i_Rst  in  1  reset, synchronous, active-high
- i_Switch  in  4  raw switch pins, active-high; bit0..3 = Switch_1..4
- i_RX_DV  in  1  one-cycle valid strobe from the UART receiver
- i_RX_Byte  in  8  received byte, qualified by i_RX_DV
- o_Level  out  4  debounced switch levels
- o_Move  out  4  one-cycle move pulses, bit n feeds game switch n+1
- o_Game_Rst  out  1  one-cycle game-restart pulse from UART

## Operation
- Debounce, per bit: if raw equals stable, clear the counter. Otherwise increment it. On the edge where count == DEBOUNCE_LIMIT-1 and raw still differs, set stable to raw and clear the counter.
- Repeat FSM, per bit, states IDLE, DELAY, REPEAT:
  - IDLE: on a stable rising edge, issue a pulse, clear the timer, go to DELAY.
  - DELAY: when timer == REPEAT_DELAY-1, issue a pulse, clear the timer, go to REPEAT.
  - REPEAT: when timer == REPEAT_PERIOD-1, issue a pulse and clear the timer.
  - Stable low in any state: go to IDLE with no pulse. Release takes priority over a timer expiry on the same cycle.
- UART decode, applied only when i_RX_DV=1; all other bytes are ignored:
  - 0x77 'w' → Move[0]
  - 0x73 's' → Move[1]
  - 0x69 'i' → Move[2]
  - 0x6B 'k' → Move[3]
  - 0x72 'r' → o_Game_Rst
- Merge: o_Move[n] = FSM pulse[n] OR UART pulse[n]. Coincident sources give one pulse, never two.
- Width rules:
  - Debounce counter width is $clog2(DEBOUNCE_LIMIT).
  - Repeat timer width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - Counters never wrap, because they are cleared on the terminal count.
- Reset values: o_Level=0, o_Move=0, o_Game_Rst=0. All counters 0, all FSMs IDLE, all stable levels 0.
- Reset with a switch held: after reset deasserts, the switch must re-debounce and then produces a fresh press pulse.

## Timing
- All outputs are registered.
- o_Level[n] rises on the DEBOUNCE_LIMIT-th consecutive edge sampling raw=1.
- o_Move[n] press pulse comes 1 cycle after o_Level[n] rises.
- First repeat pulse comes REPEAT_DELAY cycles after the press pulse; later repeats every REPEAT_PERIOD cycles while held.
- o_Level[n] falls DEBOUNCE_LIMIT edges after release. Repeat pulses stop from the cycle o_Level[n] falls.
- UART path: a pulse appears on the cycle after i_RX_DV. Back-to-back DV strobes give back-to-back pulses.
- Every pulse is exactly 1 cycle wide. Maximum pulse rate from a held switch is 1 per REPEAT_PERIOD.

## Structure
- Package paddle_input_pkg holds:
  - ASCII command constants CMD_UP1, CMD_DN1, CMD_UP2, CMD_DN2, CMD_RST
  - FSM state enum: IDLE, DELAY, REPEAT
- Sub-module switch_repeat contains one switch's debounce counter, stable level, edge detect and repeat FSM. It is instantiated 4× via generate.
- UART decode and pulse merge live in the top of this block.

## Test plan
Bench parameters: DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Glitch rejection: raw bit0 high for 3 edges, low, repeated 3× → o_Level=0, o_Move=0 throughout.
- Hold and release: raw bit0 held for 50 edges.
  - o_Level[0] rises at edge 4.
  - o_Move[0] pulses at edges 5, 25, 30, 35, 40, 45, 50.
  - No pulse after o_Level[0] falls at edge 54.
- Early release: raw bit1 held 15 edges → only the press pulse at edge 5, no repeat pulses. A re-press restarts the sequence from IDLE.
- UART decode:
  - DV with 0x73 → o_Move[1] pulse on the next cycle.
  - DV with 0x53 → nothing.
  - DV with 0x72 → o_Game_Rst pulse.
  - 0x77 with DV low → nothing.
- Coincident sources: DV with 0x77 on the same edge that the switch-0 FSM issues its press pulse → o_Move[0] high for exactly 1 cycle.
- Reset mid-REPEAT with bit2 held: i_Rst=1 for 1 edge.
  - All outputs are 0 on the next cycle.
  - o_Level[2] re-rises 4 edges after reset deasserts.
  - A press pulse follows 1 cycle later.
